// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// funct codes and datapath mux/ALU select values.
package mips_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH   = 4'd0;
    localparam state_t S_DECODE  = 4'd1;
    localparam state_t S_MEMADR  = 4'd2;
    localparam state_t S_MEMRD   = 4'd3;
    localparam state_t S_MEMWB   = 4'd4;
    localparam state_t S_MEMWR   = 4'd5;
    localparam state_t S_RTYPEEX = 4'd6;
    localparam state_t S_ALUWB   = 4'd7;
    localparam state_t S_BEQEX   = 4'd8;
    localparam state_t S_ADDIEX  = 4'd9;
    localparam state_t S_ADDIWB  = 4'd10;
    localparam state_t S_JEX     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle FSM (master) and the shared datapath (slave).
interface multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic [3:0] state;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  op, funct, zero, mem_ready,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
               alusrcb, pcsrc, pcen, alucontrol, state, instr_done, illegal
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
               alusrcb, pcsrc, pcen, alucontrol, state, instr_done, illegal
    );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU operation decode shared with the single-cycle core: aluop 00 add,
// 01 sub, 10 decode funct (unknown funct falls back to add).
module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);
    always_comb begin
        alucontrol = ALU_ADD;
        unique case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                unique case (funct)
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/
// writeback over the shared datapath and stalls on the unified memory handshake.
module multicycle_ctrl
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);
    state_t     state_q;
    state_t     state_d;
    logic [1:0] aluop;
    logic       alu_en;
    logic [2:0] dec_alu;

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct      (bus.funct),
        .alucontrol (dec_alu)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d        = S_FETCH;
        aluop          = ALUOP_ADD;
        alu_en         = 1'b0;
        bus.iord       = 1'b0;
        bus.memwrite   = 1'b0;
        bus.irwrite    = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.regwrite   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = SRCB_RT;
        bus.pcsrc      = PCSRC_ALU;
        bus.pcen       = 1'b0;
        bus.instr_done = 1'b0;
        bus.illegal    = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                alu_en      = 1'b1;
                bus.alusrcb = SRCB_FOUR;
                bus.irwrite = bus.mem_ready;
                bus.pcen    = bus.mem_ready;
                state_d     = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target is precomputed here so BEQEX only has to compare.
                alu_en      = 1'b1;
                bus.alusrcb = SRCB_IMMSH;
                unique case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default: begin
                        bus.illegal    = 1'b1;
                        bus.instr_done = 1'b1;
                        state_d        = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_en      = 1'b1;
                bus.alusrca = 1'b1;
                bus.alusrcb = SRCB_IMM;
                state_d     = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.iord = 1'b1;
                state_d  = bus.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                bus.memtoreg   = 1'b1;
                bus.regwrite   = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_MEMWR: begin
                bus.iord       = 1'b1;
                bus.memwrite   = 1'b1;
                bus.instr_done = bus.mem_ready;
                state_d        = bus.mem_ready ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: begin
                alu_en      = 1'b1;
                aluop       = ALUOP_FUNCT;
                bus.alusrca = 1'b1;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                bus.regdst     = 1'b1;
                bus.regwrite   = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_BEQEX: begin
                alu_en         = 1'b1;
                aluop          = ALUOP_SUB;
                bus.alusrca    = 1'b1;
                bus.pcsrc      = PCSRC_ALUOUT;
                bus.pcen       = bus.zero;
                bus.instr_done = 1'b1;
            end
            S_ADDIEX: begin
                alu_en      = 1'b1;
                bus.alusrca = 1'b1;
                bus.alusrcb = SRCB_IMM;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                bus.regwrite   = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_JEX: begin
                bus.pcsrc      = PCSRC_JUMP;
                bus.pcen       = 1'b1;
                bus.instr_done = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset masks every state-changing strobe so an aborted instruction has no side effects.
        if (rst) begin
            bus.memwrite   = 1'b0;
            bus.regwrite   = 1'b0;
            bus.irwrite    = 1'b0;
            bus.pcen       = 1'b0;
            bus.instr_done = 1'b0;
            bus.illegal    = 1'b0;
        end

        bus.alucontrol = alu_en ? dec_alu : '0;
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against a per-instruction step-table model.
module tb_multicycle_ctrl;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic       pcen;
        logic [2:0] alucontrol;
        logic [3:0] state;
        logic       instr_done, illegal;
    } vec_t;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5, K_ILL = 6;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic vec_t observe();
        vec_t v;
        v.iord = bus.iord;         v.memwrite = bus.memwrite; v.irwrite = bus.irwrite;
        v.regdst = bus.regdst;     v.memtoreg = bus.memtoreg; v.regwrite = bus.regwrite;
        v.alusrca = bus.alusrca;   v.alusrcb = bus.alusrcb;   v.pcsrc = bus.pcsrc;
        v.pcen = bus.pcen;         v.alucontrol = bus.alucontrol;
        v.state = bus.state;       v.instr_done = bus.instr_done; v.illegal = bus.illegal;
        return v;
    endfunction

    function automatic int kind_of(input logic [5:0] op);
        case (op)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000000: return K_R;
            6'b000100: return K_BEQ;
            6'b001000: return K_ADDI;
            6'b000010: return K_J;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic int n_steps(input int kind);
        case (kind)
            K_LW:         return 5;
            K_SW, K_R:    return 4;
            K_ADDI:       return 4;
            K_BEQ, K_J:   return 3;
            default:      return 2;
        endcase
    endfunction

    // Steps that stall on the memory handshake: instruction fetch and the data access.
    function automatic bit waits(input int kind, input int k);
        return (k == 0) || (k == 3 && (kind == K_LW || kind == K_SW));
    endfunction

    function automatic logic [2:0] rtype_alu(input logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic vec_t model(input int kind, input int k, input logic [5:0] fn,
                                   input logic mr, input logic z);
        vec_t v = '0;
        if (k == 0) begin
            v.state = 4'd0; v.alusrcb = 2'b01; v.alucontrol = 3'b010;
            v.irwrite = mr; v.pcen = mr;
        end else if (k == 1) begin
            v.state = 4'd1; v.alusrcb = 2'b11; v.alucontrol = 3'b010;
            if (kind == K_ILL) begin v.illegal = 1'b1; v.instr_done = 1'b1; end
        end else if (kind == K_LW || kind == K_SW) begin
            if (k == 2) begin
                v.state = 4'd2; v.alusrca = 1'b1; v.alusrcb = 2'b10; v.alucontrol = 3'b010;
            end else if (kind == K_LW && k == 3) begin
                v.state = 4'd3; v.iord = 1'b1;
            end else if (kind == K_LW) begin
                v.state = 4'd4; v.memtoreg = 1'b1; v.regwrite = 1'b1; v.instr_done = 1'b1;
            end else begin
                v.state = 4'd5; v.iord = 1'b1; v.memwrite = 1'b1; v.instr_done = mr;
            end
        end else if (kind == K_R) begin
            if (k == 2) begin
                v.state = 4'd6; v.alusrca = 1'b1; v.alucontrol = rtype_alu(fn);
            end else begin
                v.state = 4'd7; v.regdst = 1'b1; v.regwrite = 1'b1; v.instr_done = 1'b1;
            end
        end else if (kind == K_BEQ) begin
            v.state = 4'd8; v.alusrca = 1'b1; v.alucontrol = 3'b110; v.pcsrc = 2'b01;
            v.pcen = z; v.instr_done = 1'b1;
        end else if (kind == K_ADDI) begin
            if (k == 2) begin
                v.state = 4'd9; v.alusrca = 1'b1; v.alusrcb = 2'b10; v.alucontrol = 3'b010;
            end else begin
                v.state = 4'd10; v.regwrite = 1'b1; v.instr_done = 1'b1;
            end
        end else begin
            v.state = 4'd11; v.pcsrc = 2'b10; v.pcen = 1'b1; v.instr_done = 1'b1;
        end
        return v;
    endfunction

    // Entered and left at posedge+1; each loop pass is one clock, sampled at negedge.
    // mr_pat/zmode are only used for directed runs (rand_mr=0, zmode 0/1).
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit rand_mr,
                             input logic [15:0] mr_pat, input int zmode,
                             input int lat_exp, input int mw_exp);
        int   kind = kind_of(op);
        int   n    = n_steps(kind);
        int   k    = 0;
        int   cyc  = 0;
        int   dones = 0;
        int   mws  = 0;
        logic mr, z;
        bus.op    = op;
        bus.funct = fn;
        while (k < n && cyc < 64) begin
            mr = rand_mr ? ($urandom_range(0, 3) != 0) : mr_pat[cyc % 16];
            z  = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            bus.mem_ready = mr;
            bus.zero      = z;
            @(negedge clk);
            check($sformatf("step op=%b k=%0d", op, k), 32'(observe()), 32'(model(kind, k, fn, mr, z)));
            if (bus.instr_done) dones++;
            if (bus.memwrite) mws++;
            if (!(waits(kind, k) && !mr)) k++;
            cyc++;
            @(posedge clk);
            #1;
        end
        check("complete", 32'(k), 32'(n));
        check("done_pulses", 32'(dones), 32'd1);
        if (lat_exp >= 0) check("latency", 32'(cyc), 32'(lat_exp));
        if (mw_exp >= 0) check("memwrite_cycles", 32'(mws), 32'(mw_exp));
    endtask

    logic [5:0] fn_list [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [5:0] op_list [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

    initial begin
        logic [5:0] op, fn;
        rst = 1'b1;
        bus.op = 6'b100011; bus.funct = '0; bus.zero = 1'b1; bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", 32'(bus.state), 32'd0);
        check("reset_irwrite", 32'(bus.irwrite), 32'd0);
        check("reset_pcen", 32'(bus.pcen), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed latencies with memory always ready.
        run_instr(6'b100011, 6'd0,      0, 16'hFFFF, 0, 5, 0);
        run_instr(6'b101011, 6'd0,      0, 16'hFFFF, 0, 4, 1);
        run_instr(6'b000000, 6'b101010, 0, 16'hFFFF, 0, 4, 0);
        run_instr(6'b001000, 6'd0,      0, 16'hFFFF, 0, 4, 0);
        run_instr(6'b000100, 6'd0,      0, 16'hFFFF, 1, 3, 0);
        run_instr(6'b000100, 6'd0,      0, 16'hFFFF, 0, 3, 0);
        run_instr(6'b000010, 6'd0,      0, 16'hFFFF, 0, 3, 0);
        run_instr(6'b111111, 6'd0,      0, 16'hFFFF, 0, 2, 0);
        // sw with two not-ready cycles in MEMWR.
        run_instr(6'b101011, 6'd0,      0, 16'b1111_1111_1110_0111, 0, 6, 3);

        // Reset during a stalled MEMWR aborts the store.
        bus.op = 6'b101011; bus.funct = '0; bus.mem_ready = 1'b1; bus.zero = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.mem_ready = 1'b0;
        @(negedge clk);
        check("abort_pre_state", 32'(bus.state), 32'd5);
        check("abort_pre_memwrite", 32'(bus.memwrite), 32'd1);
        rst = 1'b1; bus.mem_ready = 1'b1;
        #1;
        check("abort_memwrite", 32'(bus.memwrite), 32'd0);
        check("abort_instr_done", 32'(bus.instr_done), 32'd0);
        @(posedge clk); #1;
        check("abort_state", 32'(bus.state), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 6) == 0) begin
                do op = 6'($urandom_range(0, 63)); while (kind_of(op) != K_ILL);
            end else begin
                op = op_list[$urandom_range(0, 5)];
            end
            fn = ($urandom_range(0, 1) == 0) ? fn_list[$urandom_range(0, 4)] : 6'($urandom_range(0, 63));
            run_instr(op, fn, 1, 16'hFFFF, 2, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle MIPS datapath inside `top`. It decodes the opcode and funct from the instruction register and sequences the shared datapath through fetch, decode, execute, memory and writeback. Every datapath enable and mux select comes from it, and it stalls on a memory-ready handshake so the single unified memory can be slowed without touching the datapath. It replaces the single-cycle `controller` when the core runs in multicycle mode.

## Interface
Parameters: none (encodings are fixed in `mips_pkg`).
- `clk` in 1: core clock (the divided `clk_run` at `top` level)
- `rst` in 1: synchronous, active-high reset
- `op` in 6: instr[31:26] from the instruction register
- `funct` in 6: instr[5:0]
- `zero` in 1: ALU zero flag, combinational, current cycle
- `mem_ready` in 1: unified memory has completed the current read or write
- `iord` out 1: memory address mux, 0 = PC, 1 = ALUOut
- `memwrite` out 1: memory write strobe
- `irwrite` out 1: instruction register load
- `regdst` out 1: 0 = rt, 1 = rd
- `memtoreg` out 1: 0 = ALUOut, 1 = data register
- `regwrite` out 1: register file write enable
- `alusrca` out 1: 0 = PC, 1 = rs
- `alusrcb` out 2: 00 = rt, 01 = 4, 10 = signimm, 11 = signimm<<2
- `pcsrc` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `pcen` out 1: PC register enable
- `alucontrol` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt
- `state` out 4: current state, for debug
- `instr_done` out 1: one-cycle pulse in the last cycle of each instruction
- `illegal` out 1: one-cycle pulse when DECODE sees an unsupported opcode

## Operation
States and next-state rules:
- FETCH(0): iord=0, alusrca=0, alusrcb=01, aluop add, pcsrc=00. irwrite and pcen are asserted only when mem_ready=1. Holds while mem_ready=0, otherwise goes to DECODE.
- DECODE(1): alusrca=0, alusrcb=11, add (branch target into ALUOut). Goes to MEMADR for lw/sw, RTYPEEX for 000000, BEQEX for 000100, ADDIEX for 001000, JEX for 000010. Any other opcode goes to FETCH with `illegal` and `instr_done` pulsed.
- MEMADR(2): alusrca=1, alusrcb=10, add. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD(3): iord=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB(4): regdst=0, memtoreg=1, regwrite=1. Goes to FETCH.
- MEMWR(5): iord=1, memwrite=1 held until mem_ready. Goes to FETCH once mem_ready=1.
- RTYPEEX(6): alusrca=1, alusrcb=00, alucontrol from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct gives add). Goes to ALUWB.
- ALUWB(7): regdst=1, memtoreg=0, regwrite=1. Goes to FETCH.
- BEQEX(8): alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=zero. Goes to FETCH.
- ADDIEX(9): alusrca=1, alusrcb=10, add. Goes to ADDIWB.
- ADDIWB(10): regdst=0, memtoreg=0, regwrite=1. Goes to FETCH.
- JEX(11): pcsrc=10, pcen=1. Goes to FETCH.

Output rules:
- Outputs not listed for a state are 0.
- All outputs are decoded combinationally from `state`. The exceptions are the `zero` term of pcen and the `mem_ready` terms in FETCH and MEMWR.
- `instr_done` is asserted in MEMWB, MEMWR (with mem_ready), ALUWB, BEQEX, ADDIWB and JEX.

## Timing
- Reset: `rst` sampled high forces state to FETCH at that edge.
- While rst=1, memwrite, regwrite, irwrite and pcen are forced to 0. instr_done and illegal are also forced to 0.
- After reset, the first FETCH cycle is the first cycle with rst=0.
- Latency with mem_ready always 1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle. No other state looks at mem_ready.
- Reset asserted mid-instruction aborts it. There is no pending write afterwards and the PC is not updated.
- Illegal states 12–15 go to FETCH on the next edge with all outputs 0.

## Structure
- `mips_pkg` holds:
  - the state enum/localparams (4-bit, encodings as numbered above)
  - opcode and funct constants
  - alucontrol, alusrcb and pcsrc encodings
- One sub-module, `alu_decoder`: combinational mapping of aluop[1:0] + funct to alucontrol, reusable by the single-cycle core. aluop is 00 = add, 01 = sub, 10 = use funct.
- The FSM has one state register and one combinational output/next-state block.

## Test plan
- Reset, then lw with mem_ready=1: states 0,1,2,3,4. regwrite=1 and memtoreg=1 only in cycle 5; instr_done pulses once.
- sw with mem_ready low for 2 cycles in MEMWR: memwrite high for 3 consecutive cycles and total latency 6. Run the `top` program and check that a write of 7 to address 84 is observed.
- beq with zero=1, then again with zero=0: pcen=1 in BEQEX only in the first case, with pcsrc=01 and alucontrol=110.
- R-type funct 101010: alucontrol=111 in RTYPEEX; regdst=1 and regwrite=1 in ALUWB.
- Opcode 111111: illegal pulses in DECODE, and the next state is FETCH with no regwrite or memwrite.
- rst asserted during MEMWR: memwrite drops the same cycle, state=FETCH after the edge, and no instr_done pulse.
